// File: rtl/link_pkg.sv
// Shared definitions for the link order arbiter and link_top: opcodes,
// arbiter FSM states and default operand widths.
package link_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_TABLE_WIDTH = 8;

    typedef enum logic [1:0] {
        APPE = 2'b00,
        DELE = 2'b01,
        CHAG = 2'b10,
        READ = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        WAIT_RSP = 2'b10
    } state_t;

    // Only READ returns data from link_top, so only READ needs a response phase.
    function automatic logic op_has_rsp(input op_t op);
        return (op == READ);
    endfunction

endpackage

// File: rtl/link_order_arb_if.sv
// Bundle of requester-side, response-side and link_top-side signals of the
// order arbiter. The arbiter uses the slave view; requesters and link_top
// together form the master view.
interface link_order_arb_if
    import link_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TABLE_WIDTH = DEF_TABLE_WIDTH
) ();

    // requester command side, requester 0 in the LSBs
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_busy;
    logic [NUM_REQ*2-1:0]           req_type;
    logic [NUM_REQ*TABLE_WIDTH-1:0] req_table;
    logic [NUM_REQ*ADDR_WIDTH-1:0]  req_node;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;

    // requester response side
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_busy;
    logic [DATA_WIDTH-1:0]          rsp_data;

    // link_top command and READ result
    logic                           order_valid;
    logic [1:0]                     order_type;
    logic [TABLE_WIDTH-1:0]         order_table;
    logic [ADDR_WIDTH-1:0]          order_node;
    logic [DATA_WIDTH-1:0]          order_data;
    logic                           order_busy;
    logic                           dout_valid;
    logic [DATA_WIDTH-1:0]          dout_data;
    logic                           dout_busy;

    modport slave (
        input  req_valid, req_type, req_table, req_node, req_data,
        input  rsp_busy, order_busy, dout_valid, dout_data,
        output req_busy, rsp_valid, rsp_data,
        output order_valid, order_type, order_table, order_node, order_data,
        output dout_busy
    );

    modport master (
        output req_valid, req_type, req_table, req_node, req_data,
        output rsp_busy, order_busy, dout_valid, dout_data,
        input  req_busy, rsp_valid, rsp_data,
        input  order_valid, order_type, order_table, order_node, order_data,
        input  dout_busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the priority pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand_s;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        grant  = {NUM_REQ{1'b0}};
        idx    = {IDX_W{1'b0}};
        any    = 1'b0;
        cand_s = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand_s]) begin
                any           = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = cand_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/link_order_arb.sv
// Arbitrates NUM_REQ requesters onto the single link_top order port with
// one command outstanding at a time; READ data is routed back to its owner.
module link_order_arb
    import link_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TABLE_WIDTH = DEF_TABLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    link_order_arb_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                 state_r, state_nxt_s;
    logic [IDX_W-1:0]       ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]       owner_r, owner_nxt_s;
    op_t                    type_r, type_nxt_s;
    logic [TABLE_WIDTH-1:0] table_r, table_nxt_s;
    logic [ADDR_WIDTH-1:0]  node_r, node_nxt_s;
    logic [DATA_WIDTH-1:0]  data_r, data_nxt_s;
    logic                   order_valid_r;

    logic [NUM_REQ-1:0]     grant_s;
    logic [IDX_W-1:0]       gidx_s;
    logic                   gany_s;

    logic [1:0]             sel_type_s;
    logic [TABLE_WIDTH-1:0] sel_table_s;
    logic [ADDR_WIDTH-1:0]  sel_node_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;

    logic [NUM_REQ-1:0]     req_busy_s;
    logic [NUM_REQ-1:0]     rsp_valid_s;
    logic [DATA_WIDTH-1:0]  rsp_data_s;
    logic                   dout_busy_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (gany_s)
    );

    // One-hot AND-OR mux of the granted requester's operands.
    always_comb begin
        sel_type_s  = 2'b00;
        sel_table_s = {TABLE_WIDTH{1'b0}};
        sel_node_s  = {ADDR_WIDTH{1'b0}};
        sel_data_s  = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_type_s  |= {2{grant_s[i]}} & bus.req_type[i*2 +: 2];
            sel_table_s |= {TABLE_WIDTH{grant_s[i]}} & bus.req_table[i*TABLE_WIDTH +: TABLE_WIDTH];
            sel_node_s  |= {ADDR_WIDTH{grant_s[i]}} & bus.req_node[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data_s  |= {DATA_WIDTH{grant_s[i]}} & bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state logic: capture a granted command in IDLE, hold it through
    // ISSUE, and wait for the READ result to be handed to its owner.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        type_nxt_s  = type_r;
        table_nxt_s = table_r;
        node_nxt_s  = node_r;
        data_nxt_s  = data_r;
        case (state_r)
            IDLE: begin
                if (gany_s) begin
                    state_nxt_s = ISSUE;
                    owner_nxt_s = gidx_s;
                    ptr_nxt_s   = (gidx_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                                  : gidx_s + IDX_W'(1);
                    type_nxt_s  = op_t'(sel_type_s);
                    table_nxt_s = sel_table_s;
                    node_nxt_s  = sel_node_s;
                    data_nxt_s  = sel_data_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (!bus.order_busy) begin
                    state_nxt_s = op_has_rsp(type_r) ? WAIT_RSP : IDLE;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT_RSP: begin
                if (bus.dout_valid && !bus.rsp_busy[owner_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake outputs: grant stall in IDLE, response routing in WAIT_RSP.
    always_comb begin
        req_busy_s  = {NUM_REQ{1'b1}};
        rsp_valid_s = {NUM_REQ{1'b0}};
        rsp_data_s  = {DATA_WIDTH{1'b0}};
        dout_busy_s = 1'b0;
        case (state_r)
            IDLE: begin
                req_busy_s = ~grant_s;
            end
            ISSUE: begin
                req_busy_s = {NUM_REQ{1'b1}};
            end
            WAIT_RSP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid_s[i] = bus.dout_valid & (owner_r == IDX_W'(i));
                end
                rsp_data_s  = bus.dout_data;
                dout_busy_s = bus.rsp_busy[owner_r];
            end
            default: begin
                req_busy_s = {NUM_REQ{1'b1}};
            end
        endcase
    end

    // State, pointer and registered command; reset abandons any command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            ptr_r         <= {IDX_W{1'b0}};
            owner_r       <= {IDX_W{1'b0}};
            type_r        <= APPE;
            table_r       <= {TABLE_WIDTH{1'b0}};
            node_r        <= {ADDR_WIDTH{1'b0}};
            data_r        <= {DATA_WIDTH{1'b0}};
            order_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ptr_r         <= ptr_nxt_s;
            owner_r       <= owner_nxt_s;
            type_r        <= type_nxt_s;
            table_r       <= table_nxt_s;
            node_r        <= node_nxt_s;
            data_r        <= data_nxt_s;
            order_valid_r <= (state_nxt_s == ISSUE);
        end
    end

    assign bus.req_busy    = req_busy_s;
    assign bus.rsp_valid   = rsp_valid_s;
    assign bus.rsp_data    = rsp_data_s;
    assign bus.dout_busy   = dout_busy_s;
    assign bus.order_valid = order_valid_r;
    assign bus.order_type  = type_r;
    assign bus.order_table = table_r;
    assign bus.order_node  = node_r;
    assign bus.order_data  = data_r;

endmodule

// File: tb/tb_link_order_arb.sv
// Directed self-checking bench for link_order_arb (4 requesters, 16/16/8 widths).
module tb_link_order_arb;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    link_order_arb_if bus ();

    link_order_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.order_valid, bus.rsp_valid, bus.dout_busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ov=%b rv=%b db=%b expected all 0",
                     bus.order_valid, bus.rsp_valid, bus.dout_busy);
        end
        rst = 1'b0;
        checks++;
        if (bus.req_busy !== 4'b1111) begin
            failures++;
            $display("FAIL reset_busy_idle: got %b expected 1111", bus.req_busy);
        end
        checks++;
        if ({bus.order_type, bus.order_table, bus.order_node, bus.order_data} !== 42'd0) begin
            failures++;
            $display("FAIL reset_order_fields: got %h/%h/%h/%h expected 0",
                     bus.order_type, bus.order_table, bus.order_node, bus.order_data);
        end
        bus.req_valid = 4'b1111;
        #1;
        checks++;
        if (bus.req_busy !== 4'b1110) begin
            failures++;
            $display("FAIL reset_ptr_grant: got %b expected 1110", bus.req_busy);
        end
        bus.req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_single_append;
        bus.req_type[2*2 +: 2]   = 2'b00;
        bus.req_table[2*8 +: 8]  = 8'd3;
        bus.req_node[2*16 +: 16] = 16'd1;
        bus.req_data[2*16 +: 16] = 16'd111;
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_busy !== 4'b1011) begin
            failures++;
            $display("FAIL single_grant: got %b expected 1011", bus.req_busy);
        end
        tick();
        bus.req_valid = 4'b0000;
        checks++;
        if ({bus.order_valid, bus.order_type, bus.order_table, bus.order_node, bus.order_data}
            !== {1'b1, 2'b00, 8'd3, 16'd1, 16'd111}) begin
            failures++;
            $display("FAIL single_order: got v=%b t=%0d tb=%0d n=%0d d=%0d expected 1/0/3/1/111",
                     bus.order_valid, bus.order_type, bus.order_table, bus.order_node, bus.order_data);
        end
        checks++;
        if (bus.req_busy !== 4'b1111) begin
            failures++;
            $display("FAIL single_busy_issue: got %b expected 1111", bus.req_busy);
        end
        tick();
        checks++;
        if (bus.order_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_one_cycle: got order_valid=%b expected 0", bus.order_valid);
        end
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_busy !== 4'b1011) begin
            failures++;
            $display("FAIL single_regrant: got %b expected 1011", bus.req_busy);
        end
        bus.req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_round_robin;
        int         exp_g [5];
        logic [1:0] exp_t [4];
        logic [3:0] exp_busy;
        exp_g = '{0, 1, 2, 3, 0};
        exp_t = '{2'b00, 2'b01, 2'b10, 2'b00};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            bus.req_type[r*2 +: 2]   = exp_t[r];
            bus.req_table[r*8 +: 8]  = 8'(r);
            bus.req_node[r*16 +: 16] = 16'(r);
            bus.req_data[r*16 +: 16] = 16'(100 + r);
        end
        bus.req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            exp_busy = ~(4'b0001 << exp_g[i]);
            checks++;
            if ({bus.order_valid, bus.req_busy} !== {1'b0, exp_busy}) begin
                failures++;
                $display("FAIL rr_grant_%0d: got ov=%b busy=%b expected ov=0 busy=%b",
                         i, bus.order_valid, bus.req_busy, exp_busy);
            end
            tick();
            checks++;
            if ({bus.order_valid, bus.order_type, bus.order_data}
                !== {1'b1, exp_t[exp_g[i]], 16'(100 + exp_g[i])}) begin
                failures++;
                $display("FAIL rr_order_%0d: got v=%b t=%0d d=%0d expected 1/%0d/%0d",
                         i, bus.order_valid, bus.order_type, bus.order_data,
                         exp_t[exp_g[i]], 100 + exp_g[i]);
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_read_stall;
        bus.order_busy = 1'b1;
        bus.req_type[1*2 +: 2]   = 2'b11;
        bus.req_table[1*8 +: 8]  = 8'd5;
        bus.req_node[1*16 +: 16] = 16'd2;
        bus.req_data[1*16 +: 16] = 16'd0;
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_busy !== 4'b1101) begin
            failures++;
            $display("FAIL read_grant: got %b expected 1101", bus.req_busy);
        end
        tick();
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({bus.order_valid, bus.order_type, bus.order_table, bus.order_node}
                !== {1'b1, 2'b11, 8'd5, 16'd2}) begin
                failures++;
                $display("FAIL read_stable_%0d: got v=%b t=%0d tb=%0d n=%0d expected 1/3/5/2",
                         c, bus.order_valid, bus.order_type, bus.order_table, bus.order_node);
            end
            if (c == 5) begin
                bus.order_busy = 1'b0;
            end
            tick();
        end
        checks++;
        if ({bus.order_valid, bus.rsp_valid, bus.req_busy} !== {1'b0, 4'b0000, 4'b1111}) begin
            failures++;
            $display("FAIL read_wait_state: got ov=%b rv=%b busy=%b expected 0/0000/1111",
                     bus.order_valid, bus.rsp_valid, bus.req_busy);
        end
        bus.dout_valid = 1'b1;
        bus.dout_data  = 16'd112;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.dout_busy} !== {4'b0010, 16'd112, 1'b0}) begin
            failures++;
            $display("FAIL read_rsp: got rv=%b rd=%0d db=%b expected 0010/112/0",
                     bus.rsp_valid, bus.rsp_data, bus.dout_busy);
        end
        tick();
        bus.dout_valid = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.order_valid} !== 5'b0) begin
            failures++;
            $display("FAIL read_done: got rv=%b ov=%b expected 0", bus.rsp_valid, bus.order_valid);
        end
    endtask

    task automatic test_rsp_backpressure;
        bus.req_type[3*2 +: 2]   = 2'b11;
        bus.req_node[3*16 +: 16] = 16'd9;
        bus.req_valid = 4'b1000;
        #1;
        checks++;
        if (bus.req_busy !== 4'b0111) begin
            failures++;
            $display("FAIL bp_grant: got %b expected 0111", bus.req_busy);
        end
        tick();
        bus.req_valid = 4'b0000;
        checks++;
        if (bus.order_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_issue: got order_valid=%b expected 1", bus.order_valid);
        end
        tick();
        bus.req_valid  = 4'b0001;
        bus.dout_valid = 1'b1;
        bus.dout_data  = 16'd77;
        bus.rsp_busy   = 4'b1000;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.dout_busy, bus.rsp_valid, bus.req_busy, bus.order_valid}
                !== {1'b1, 4'b1000, 4'b1111, 1'b0}) begin
                failures++;
                $display("FAIL bp_stall_%0d: got db=%b rv=%b busy=%b ov=%b expected 1/1000/1111/0",
                         c, bus.dout_busy, bus.rsp_valid, bus.req_busy, bus.order_valid);
            end
            tick();
        end
        bus.rsp_busy = 4'b0000;
        #1;
        checks++;
        if ({bus.dout_busy, bus.rsp_valid, bus.rsp_data} !== {1'b0, 4'b1000, 16'd77}) begin
            failures++;
            $display("FAIL bp_release: got db=%b rv=%b rd=%0d expected 0/1000/77",
                     bus.dout_busy, bus.rsp_valid, bus.rsp_data);
        end
        tick();
        bus.dout_valid = 1'b0;
        #1;
        checks++;
        if ({bus.req_busy, bus.order_valid} !== {4'b1110, 1'b0}) begin
            failures++;
            $display("FAIL bp_next_grant: got busy=%b ov=%b expected 1110/0",
                     bus.req_busy, bus.order_valid);
        end
        bus.req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_reset_mid_issue;
        bus.req_type[2*2 +: 2] = 2'b00;
        bus.order_busy = 1'b1;
        bus.req_valid  = 4'b0100;
        #1;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++;
        if (bus.order_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_issue_held: got order_valid=%b expected 1", bus.order_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.order_valid, bus.rsp_valid, bus.dout_busy} !== 6'b0) begin
            failures++;
            $display("FAIL mid_issue_abandon: got ov=%b rv=%b db=%b expected 0",
                     bus.order_valid, bus.rsp_valid, bus.dout_busy);
        end
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        checks++;
        if (bus.req_busy !== 4'b1110) begin
            failures++;
            $display("FAIL mid_issue_ptr: got %b expected 1110", bus.req_busy);
        end
        bus.req_valid  = 4'b0000;
        bus.order_busy = 1'b0;
        tick();
        checks++;
        if (bus.order_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_issue_idle: got order_valid=%b expected 0", bus.order_valid);
        end
    endtask

    task automatic test_stray_dout;
        bus.dout_valid = 1'b1;
        bus.dout_data  = 16'd55;
        bus.rsp_busy   = 4'b1111;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.dout_busy} !== 5'b0) begin
            failures++;
            $display("FAIL stray_now: got rv=%b db=%b expected 0", bus.rsp_valid, bus.dout_busy);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.dout_busy, bus.order_valid} !== 6'b0) begin
            failures++;
            $display("FAIL stray_next: got rv=%b db=%b ov=%b expected 0",
                     bus.rsp_valid, bus.dout_busy, bus.order_valid);
        end
        bus.dout_valid = 1'b0;
        bus.rsp_busy   = 4'b0000;
        #1;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.req_valid  = 4'b0000;
        bus.req_type   = 8'd0;
        bus.req_table  = 32'd0;
        bus.req_node   = 64'd0;
        bus.req_data   = 64'd0;
        bus.rsp_busy   = 4'b0000;
        bus.order_busy = 1'b0;
        bus.dout_valid = 1'b0;
        bus.dout_data  = 16'd0;

        test_reset();
        test_single_append();
        test_round_robin();
        test_read_stall();
        test_rsp_backpressure();
        test_reset_mid_issue();
        test_stray_dout();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
